// File: rtl/nfca_pkg.sv
// -----------------------------------------------------------------------------
// nfca_pkg
//   Shared types, timing defaults and helpers for the ISO14443A PCD transmit
//   path at 106 kbit/s, with clk running at 81.36 MHz (6 x fc).
//
//   Contents
//     miller_sym_t           Modified-Miller symbol of one ETU
//     CARRIER_DIV_DEFAULT    clk cycles per 13.56 MHz carrier period
//     ETU_CYC_DEFAULT        clk cycles per bit (128/fc)
//     PAUSE_CYC_DEFAULT      100% ASK pause width in clk cycles (32/fc)
//     miller_select()        symbol chosen for the coming ETU
// -----------------------------------------------------------------------------
package nfca_pkg;

   typedef enum logic [1:0] {
      SYM_IDLE,   // nothing sampled since reset, no pause
      SYM_X,      // pause in the second half of the ETU
      SYM_Y,      // no pause for the whole ETU
      SYM_Z       // pause at the start of the ETU
   } miller_sym_t;

   localparam int CARRIER_DIV_DEFAULT = 6;
   localparam int ETU_CYC_DEFAULT     = 768;
   localparam int PAUSE_CYC_DEFAULT   = 192;

   // Modified-Miller symbol for one ETU.
   //   en/tx_bit         : what upstream offers for the coming ETU
   //   prev_en/prev_bit  : what was sent in the ETU before
   // A frame always opens with Z; a logic 1 is X; a logic 0 is Y when it
   // directly follows a 1 and Z otherwise; no data means Y.
   function automatic miller_sym_t miller_select(
      input logic en,
      input logic tx_bit,
      input logic prev_en,
      input logic prev_bit
   );
      miller_sym_t sym;
      if (!en) begin
         sym = SYM_Y;
      end else if (!prev_en) begin
         sym = SYM_Z;
      end else if (tx_bit) begin
         sym = SYM_X;
      end else if (prev_bit) begin
         sym = SYM_Y;
      end else begin
         sym = SYM_Z;
      end
      return sym;
   endfunction

endpackage : nfca_pkg

// File: rtl/nfca_etu_timer.sv
// -----------------------------------------------------------------------------
// nfca_etu_timer
//   Free-running bit-phase and carrier-phase counters for the PCD modulator,
//   plus the one-cycle tx_req strobe that paces the upstream frame builder.
//
//   Ports
//     clk        in   clock (81.36 MHz)
//     rstn       in   synchronous reset, active-low
//     ph         out  bit phase, 0..ETU_CYC-1, wraps
//     cph        out  carrier phase, 0..CARRIER_DIV-1, wraps
//     etu_start  out  1 while ph==0 (the symbol sampling cycle)
//     tx_req     out  registered pulse, high while ph==ETU_CYC-1
//
//   The counters run whenever rstn=1 regardless of field or data state, so
//   the upstream builder is paced at a constant rate.
// -----------------------------------------------------------------------------
module nfca_etu_timer
   import nfca_pkg::*;
#(
   parameter  int CARRIER_DIV = CARRIER_DIV_DEFAULT,
   parameter  int ETU_CYC     = ETU_CYC_DEFAULT,
   localparam int PH_W        = $clog2(ETU_CYC),
   localparam int CPH_W       = $clog2(CARRIER_DIV)
) (
   input  logic             clk,
   input  logic             rstn,
   output logic [PH_W-1:0]  ph,
   output logic [CPH_W-1:0] cph,
   output logic             etu_start,
   output logic             tx_req
);

   localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(ETU_CYC - 1);
   localparam logic [PH_W-1:0]  PH_REQ_PRE  = PH_W'(ETU_CYC - 2);
   localparam logic [CPH_W-1:0] CPH_LAST    = CPH_W'(CARRIER_DIV - 1);

   logic [PH_W-1:0]  ph_reg;
   logic [PH_W-1:0]  ph_next;
   logic [CPH_W-1:0] cph_reg;
   logic [CPH_W-1:0] cph_next;
   logic             tx_req_reg;
   logic             tx_req_next;
   logic             ph_wrap;

   always_comb begin
      ph_wrap     = (ph_reg == PH_LAST);
      ph_next     = ph_wrap ? '0 : ph_reg + PH_W'(1);
      // Clearing cph on the ETU wrap keeps every ETU edge on a carrier
      // period boundary even if the two ever fell out of step.
      cph_next    = (ph_wrap || (cph_reg == CPH_LAST)) ? '0 : cph_reg + CPH_W'(1);
      // Decoded one phase early so the registered strobe lines up with
      // ph==ETU_CYC-1 and upstream can present new data during ph==0.
      tx_req_next = (ph_reg == PH_REQ_PRE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ph_reg     <= '0;
         cph_reg    <= '0;
         tx_req_reg <= 1'b0;
      end else begin
         ph_reg     <= ph_next;
         cph_reg    <= cph_next;
         tx_req_reg <= tx_req_next;
      end
   end

   assign ph        = ph_reg;
   assign cph       = cph_reg;
   assign etu_start = (ph_reg == '0);
   assign tx_req    = tx_req_reg;

endmodule : nfca_etu_timer

// File: rtl/nfca_tx_modulate.sv
// -----------------------------------------------------------------------------
// nfca_tx_modulate
//   PCD-side bit modulator for ISO14443A at 106 kbit/s. Paces the upstream
//   frame builder with one tx_req per ETU, samples tx_en/tx_bit once per ETU,
//   applies Modified-Miller coding (X/Y/Z sequences, 100% ASK pauses) and
//   emits the gated 13.56 MHz carrier for the RF front end.
//
//   Ports
//     clk          in   81.36 MHz clock (6 x fc)
//     rstn         in   synchronous reset, active-low
//     rf_on        in   1 = field enabled, 0 = carrier_out held low
//     tx_req       out  1-cycle pulse at ph==ETU_CYC-1; upstream updates
//                       tx_en/tx_bit in the following cycle
//     tx_en        in   tx_bit is valid for the coming ETU (S and E included)
//     tx_bit       in   bit value for the coming ETU
//     pause_n      out  modulation envelope, 0 = field paused
//     carrier_out  out  carrier & pause_n & rf_on, one register stage
//     tx_active    out  high from the first modulated ETU through the
//                       trailing Y ETU; used for RX blanking
//
//   Timing
//     tx_en/tx_bit are sampled on the edge that ends ph==0. The pause
//     envelope is registered and appears two cycles after that sample:
//       Z : pause_n=0 for ph in [2, PAUSE_CYC+1]
//       X : pause_n=0 for ph in [ETU_CYC/2+2, ETU_CYC/2+PAUSE_CYC+1]
//     Coding state keeps running while rf_on=0; only the carrier is gated.
// -----------------------------------------------------------------------------
module nfca_tx_modulate
   import nfca_pkg::*;
#(
   parameter int CARRIER_DIV = CARRIER_DIV_DEFAULT,
   parameter int ETU_CYC     = ETU_CYC_DEFAULT,
   parameter int PAUSE_CYC   = PAUSE_CYC_DEFAULT
) (
   input  logic clk,
   input  logic rstn,
   input  logic rf_on,
   output logic tx_req,
   input  logic tx_en,
   input  logic tx_bit,
   output logic pause_n,
   output logic carrier_out,
   output logic tx_active
);

   localparam int PH_W  = $clog2(ETU_CYC);
   localparam int CPH_W = $clog2(CARRIER_DIV);

   // Pause windows expressed in the phase seen one cycle before pause_n
   // updates, because pause_n is itself a register on top of sym_reg.
   localparam logic [PH_W-1:0]  Z_FIRST   = PH_W'(1);
   localparam logic [PH_W-1:0]  Z_LAST    = PH_W'(PAUSE_CYC);
   localparam logic [PH_W-1:0]  X_FIRST   = PH_W'(ETU_CYC / 2 + 1);
   localparam logic [PH_W-1:0]  X_LAST    = PH_W'(ETU_CYC / 2 + PAUSE_CYC);
   localparam logic [CPH_W-1:0] CPH_HIGH  = CPH_W'(CARRIER_DIV / 2);

   // Elaboration guard: the pause windows and the carrier alignment only
   // make sense for these parameter relationships.
   if (((ETU_CYC % 2) != 0) || ((ETU_CYC % CARRIER_DIV) != 0) ||
       (PAUSE_CYC >= ETU_CYC / 2) || (CARRIER_DIV < 2)) begin : g_bad_params
      $error("nfca_tx_modulate: inconsistent ETU_CYC/CARRIER_DIV/PAUSE_CYC");
   end

   // ---------------------------------------------------------------------
   // Bit and carrier timing
   // ---------------------------------------------------------------------
   logic [PH_W-1:0]  ph;
   logic [CPH_W-1:0] cph;
   logic             etu_start;

   nfca_etu_timer #(
      .CARRIER_DIV (CARRIER_DIV),
      .ETU_CYC     (ETU_CYC)
   ) u_etu_timer (
      .clk       (clk),
      .rstn      (rstn),
      .ph        (ph),
      .cph       (cph),
      .etu_start (etu_start),
      .tx_req    (tx_req)
   );

   // ---------------------------------------------------------------------
   // Miller encoder and envelope state
   // ---------------------------------------------------------------------
   miller_sym_t sym_reg;
   miller_sym_t sym_next;
   logic        prev_en_reg;
   logic        prev_en_next;
   logic        prev_bit_reg;
   logic        prev_bit_next;
   logic        tx_active_reg;
   logic        tx_active_next;
   logic        pause_n_reg;
   logic        pause_n_next;
   logic        carrier_reg;
   logic        carrier_next;
   logic        in_z_window;
   logic        in_x_window;

   always_comb begin
      sym_next       = sym_reg;
      prev_en_next   = prev_en_reg;
      prev_bit_next  = prev_bit_reg;
      tx_active_next = tx_active_reg;

      if (etu_start) begin
         sym_next       = miller_select(tx_en, tx_bit, prev_en_reg, prev_bit_reg);
         prev_en_next   = tx_en;
         // A gap ETU counts as a 0, so a frame starting after it is not
         // mistaken for a 0 following a 1.
         prev_bit_next  = tx_en & tx_bit;
         // While data flows this is 1; on the first empty ETU it keeps the
         // previous tx_en, covering exactly one trailing Y ETU.
         tx_active_next = tx_en | prev_en_reg;
      end

      // The windows never include ph==0, so the stale sym_reg seen during
      // the sampling cycle cannot produce a pause.
      in_z_window  = (ph >= Z_FIRST) && (ph <= Z_LAST);
      in_x_window  = (ph >= X_FIRST) && (ph <= X_LAST);
      pause_n_next = !(((sym_reg == SYM_Z) && in_z_window) ||
                       ((sym_reg == SYM_X) && in_x_window));

      // Carrier gated with the envelope value that is about to be
      // registered, so carrier_out and pause_n switch on the same edge.
      carrier_next = (cph < CPH_HIGH) & pause_n_next & rf_on;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sym_reg       <= SYM_IDLE;
         prev_en_reg   <= 1'b0;
         prev_bit_reg  <= 1'b0;
         tx_active_reg <= 1'b0;
         pause_n_reg   <= 1'b1;
         carrier_reg   <= 1'b0;
      end else begin
         sym_reg       <= sym_next;
         prev_en_reg   <= prev_en_next;
         prev_bit_reg  <= prev_bit_next;
         tx_active_reg <= tx_active_next;
         pause_n_reg   <= pause_n_next;
         carrier_reg   <= carrier_next;
      end
   end

   assign pause_n     = pause_n_reg;
   assign carrier_out = carrier_reg;
   assign tx_active   = tx_active_reg;

endmodule : nfca_tx_modulate
